// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one memory read per instruction, presents
// the result to decode, and follows redirects/HALT on the consuming edge.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCsel_In_FromD,
    input  logic [15:0] BJAddr_In_FromD,
    input  logic        Halt_In_FromD,
    input  logic        Stall_In,
    input  logic [15:0] IMemRdata,
    input  logic        IMemDone,
    output logic        IMemReq,
    output logic [15:0] IMemAddr,
    output logic [15:0] Instr_Out_ToD,
    output logic [15:0] PCInc_Out_ToD,
    output logic        Valid_Out_ToD,
    output logic        Halted,
    output logic        err
);

    typedef enum logic [1:0] {FETCH, WAIT, PRESENT, HALTED} stateT;

    localparam logic [15:0] NopInstr = 16'h0800;

    stateT       state, stateNext;
    logic [15:0] pc, pcNext;
    logic [15:0] instr, instrNext;
    logic [15:0] pcInc, pcIncNext;
    logic        halted, haltedNext;
    logic        errQ, errNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FETCH;
            pc     <= '0;
            instr  <= NopInstr;
            pcInc  <= '0;
            halted <= 1'b0;
            errQ   <= 1'b0;
        end else begin
            state  <= stateNext;
            pc     <= pcNext;
            instr  <= instrNext;
            pcInc  <= pcIncNext;
            halted <= haltedNext;
            errQ   <= errNext;
        end
    end

    always_comb begin
        stateNext  = state;
        pcNext     = pc;
        instrNext  = instr;
        pcIncNext  = pcInc;
        haltedNext = halted;
        errNext    = errQ;

        case (state)
            FETCH: stateNext = WAIT;
            WAIT: begin
                if (IMemDone) begin
                    instrNext = IMemRdata;
                    pcIncNext = pc + 16'd2;
                    stateNext = PRESENT;
                end
            end
            PRESENT: begin
                // Redirect/halt only act on the consuming edge, so a request
                // held across stall cycles is taken exactly once.
                if (!Stall_In) begin
                    if (Halt_In_FromD) begin
                        stateNext  = HALTED;
                        haltedNext = 1'b1;
                    end else if (PCsel_In_FromD) begin
                        pcNext    = {BJAddr_In_FromD[15:1], 1'b0};
                        stateNext = FETCH;
                        if (BJAddr_In_FromD[0]) begin
                            errNext = 1'b1;
                        end
                    end else begin
                        pcNext    = pc + 16'd2;
                        stateNext = FETCH;
                    end
                end
            end
            HALTED: stateNext = HALTED;
            default: stateNext = FETCH;
        endcase

        if (IMemDone && state != WAIT) begin
            errNext = 1'b1;
        end
    end

    assign IMemReq       = (state == FETCH);
    assign Valid_Out_ToD = (state == PRESENT);
    assign IMemAddr      = pc;
    assign Instr_Out_ToD = instr;
    assign PCInc_Out_ToD = pcInc;
    assign Halted        = halted;
    assign err           = errQ;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle instruction memory model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCsel_In_FromD;
    logic [15:0] BJAddr_In_FromD;
    logic        Halt_In_FromD;
    logic        Stall_In;
    logic [15:0] IMemRdata;
    logic        IMemDone;
    logic        IMemReq;
    logic [15:0] IMemAddr;
    logic [15:0] Instr_Out_ToD;
    logic [15:0] PCInc_Out_ToD;
    logic        Valid_Out_ToD;
    logic        Halted;
    logic        err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic        injectDone = 1'b0;
    logic        memPend;
    logic [15:0] memAddr;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .PCsel_In_FromD (PCsel_In_FromD),
        .BJAddr_In_FromD(BJAddr_In_FromD),
        .Halt_In_FromD  (Halt_In_FromD),
        .Stall_In       (Stall_In),
        .IMemRdata      (IMemRdata),
        .IMemDone       (IMemDone),
        .IMemReq        (IMemReq),
        .IMemAddr       (IMemAddr),
        .Instr_Out_ToD  (Instr_Out_ToD),
        .PCInc_Out_ToD  (PCInc_Out_ToD),
        .Valid_Out_ToD  (Valid_Out_ToD),
        .Halted         (Halted),
        .err            (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memData(input logic [15:0] a);
        return (a == 16'h0000) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    // Responds one cycle after a request; a reset at the request edge drops it.
    always @(posedge clk) begin
        memPend = IMemReq && !rst;
        memAddr = IMemAddr;
        #1;
        IMemDone  = memPend || injectDone;
        IMemRdata = memPend ? memData(memAddr) : 16'h0000;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; PCsel_In_FromD = 1'b0; BJAddr_In_FromD = '0;
        Halt_In_FromD = 1'b0; Stall_In = 1'b0; IMemDone = 1'b0; IMemRdata = '0;
        step(); step();
        chk("rst_instr", Instr_Out_ToD, 16'h0800);
        chk("rst_pcinc", PCInc_Out_ToD, 16'h0000);
        chk("rst_valid", Valid_Out_ToD, 16'd0);
        chk("rst_halted", Halted, 16'd0);
        chk("rst_err", err, 16'd0);
        rst = 1'b0;
        // n0: first request
        chk("c1_req", IMemReq, 16'd1);
        chk("c1_addr", IMemAddr, 16'h0000);
        step(); // n1 WAIT
        chk("c2_req", IMemReq, 16'd0);
        chk("c2_done", IMemDone, 16'd1);
        chk("c2_valid", Valid_Out_ToD, 16'd0);
        step(); // n2 PRESENT
        chk("c3_valid", Valid_Out_ToD, 16'd1);
        chk("c3_instr", Instr_Out_ToD, 16'h1234);
        chk("c3_pcinc", PCInc_Out_ToD, 16'h0002);
        step(); // n3 FETCH
        chk("c4_req", IMemReq, 16'd1);
        chk("c4_addr", IMemAddr, 16'h0002);

        // Stall for three PRESENT cycles
        step(); // n4 WAIT
        Stall_In = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); // n5..n7
            chk("stall_valid", Valid_Out_ToD, 16'd1);
            chk("stall_req", IMemReq, 16'd0);
            chk("stall_instr", Instr_Out_ToD, 16'hA5A7);
            chk("stall_pcinc", PCInc_Out_ToD, 16'h0004);
        end
        Stall_In = 1'b0;
        step(); // n8
        chk("post_stall_req", IMemReq, 16'd1);
        chk("post_stall_addr", IMemAddr, 16'h0004);

        // Redirect held across two stall cycles
        step(); // n9 WAIT
        PCsel_In_FromD = 1'b1; BJAddr_In_FromD = 16'h0040; Stall_In = 1'b1;
        step(); // n10
        chk("redir_instr", Instr_Out_ToD, 16'hA5A1);
        step(); // n11
        chk("redir_hold_valid", Valid_Out_ToD, 16'd1);
        step(); // n12
        Stall_In = 1'b0;
        step(); // n13
        chk("redir_req", IMemReq, 16'd1);
        chk("redir_addr", IMemAddr, 16'h0040);
        chk("redir_err", err, 16'd0);
        step(); // n14 WAIT
        PCsel_In_FromD = 1'b0;
        step(); // n15 PRESENT
        chk("redir_fetch_instr", Instr_Out_ToD, 16'hA5E5);
        chk("redir_fetch_pcinc", PCInc_Out_ToD, 16'h0042);
        step(); // n16
        chk("redir_once_addr", IMemAddr, 16'h0042);

        // Wrap from 0xFFFE
        step(); // n17
        PCsel_In_FromD = 1'b1; BJAddr_In_FromD = 16'hFFFE;
        step(); // n18
        chk("pre_wrap_instr", Instr_Out_ToD, 16'hA5E7);
        step(); // n19
        chk("wrap_addr", IMemAddr, 16'hFFFE);
        PCsel_In_FromD = 1'b0;
        step(); step(); // n21
        chk("wrap_instr", Instr_Out_ToD, 16'h5A5B);
        chk("wrap_pcinc", PCInc_Out_ToD, 16'h0000);
        step(); // n22
        chk("wrap_next_addr", IMemAddr, 16'h0000);
        chk("wrap_err", err, 16'd0);

        // Misaligned redirect
        step(); // n23
        PCsel_In_FromD = 1'b1; BJAddr_In_FromD = 16'h0041;
        step(); // n24
        chk("mis_instr", Instr_Out_ToD, 16'h1234);
        step(); // n25
        chk("mis_addr", IMemAddr, 16'h0040);
        chk("mis_err", err, 16'd1);
        PCsel_In_FromD = 1'b0;
        rst = 1'b1;
        step(); // n26
        chk("mis_rst_err", err, 16'd0);
        chk("mis_rst_addr", IMemAddr, 16'h0000);
        rst = 1'b0;
        step(); step(); // n28
        chk("rerun_instr", Instr_Out_ToD, 16'h1234);
        injectDone = 1'b1;
        step(); // n29 FETCH
        injectDone = 1'b0;
        chk("inj_err_before", err, 16'd0);
        step(); // n30
        chk("inj_err", err, 16'd1);
        step(); // n31 PRESENT
        chk("inj_err_held", err, 16'd1);
        chk("inj_instr", Instr_Out_ToD, 16'hA5A7);

        // HALT wins over redirect
        Halt_In_FromD = 1'b1; PCsel_In_FromD = 1'b1; BJAddr_In_FromD = 16'h0080;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("halt_halted", Halted, 16'd1);
            chk("halt_req", IMemReq, 16'd0);
            chk("halt_valid", Valid_Out_ToD, 16'd0);
            chk("halt_pc", IMemAddr, 16'h0002);
        end
        Halt_In_FromD = 1'b0; PCsel_In_FromD = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("halt_rst_halted", Halted, 16'd0);
        chk("halt_rst_addr", IMemAddr, 16'h0000);
        chk("halt_rst_err", err, 16'd0);
        chk("halt_rst_req", IMemReq, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have one clock and one synchronous active-high reset: clk input, rst input; all state changes on rising clk edge.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 PCsel_In_FromD  input  1  redirect request from decode; 1 = take BJAddr_In_FromD.
REQ-005 BJAddr_In_FromD  input  16  branch/jump target address.
REQ-006 Halt_In_FromD  input  1  presented instruction is HALT.
REQ-007 Stall_In  input  1  decode cannot accept the presented instruction.
REQ-008 IMemRdata  input  16  instruction memory read data, valid when IMemDone=1.
REQ-009 IMemDone  input  1  instruction memory response strobe.
REQ-010 IMemReq  output  1  instruction memory read request.
REQ-011 IMemAddr  output  16  instruction memory read address.
REQ-012 Instr_Out_ToD  output  16  instruction presented to decode.
REQ-013 PCInc_Out_ToD  output  16  address of presented instruction + 2.
REQ-014 Valid_Out_ToD  output  1  Instr_Out_ToD/PCInc_Out_ToD are valid.
REQ-015 Halted  output  1  fetch stopped by HALT.
REQ-016 err  output  1  sticky protocol/alignment error.

Function
REQ-017 SHALL implement FSM states FETCH, WAIT, PRESENT, HALTED.
REQ-018 FETCH: IMemReq=1, IMemAddr=PC; SHALL go to WAIT next cycle unconditionally.
REQ-019 WAIT: IMemReq=0, IMemAddr=PC; SHALL stay until IMemDone=1, then capture IMemRdata into Instr_Out_ToD, PC+2 into PCInc_Out_ToD, and go to PRESENT.
REQ-020 PRESENT: Valid_Out_ToD=1; instruction consumed at an edge where Stall_In=0; while Stall_In=1, SHALL hold state, PC, Instr_Out_ToD and PCInc_Out_ToD unchanged, with IMemReq=0.
REQ-021 On consume with Halt_In_FromD=0 and PCsel_In_FromD=0: PC <= PC+2, next state FETCH.
REQ-022 On consume with PCsel_In_FromD=1 and Halt_In_FromD=0: PC <= {BJAddr_In_FromD[15:1],1'b0}, next state FETCH.
REQ-023 On consume with Halt_In_FromD=1: SHALL go to HALTED regardless of PCsel_In_FromD; PC unchanged.
REQ-024 PCsel_In_FromD and Halt_In_FromD SHALL be ignored outside a consuming PRESENT cycle; a redirect held across stall cycles SHALL be taken exactly once.
REQ-025 HALTED: IMemReq=0, Valid_Out_ToD=0, Halted=1; SHALL remain until rst.
REQ-026 Minimum latency: request to Valid_Out_ToD = 2 cycles with 1-cycle memory; one instruction per 3 cycles minimum throughput.
REQ-027 PC arithmetic SHALL be 16-bit modulo: 0xFFFE + 2 = 0x0000; no error on wrap.
REQ-028 err SHALL set and stay 1 until rst when: IMemDone=1 in any state other than WAIT, or a taken redirect has BJAddr_In_FromD[0]=1.
REQ-029 Valid_Out_ToD and IMemReq SHALL be decoded from the registered state only; all other outputs SHALL be registered.

Reset
REQ-030 In any state, rst=1 at an edge SHALL set PC=0x0000, state=FETCH, Instr_Out_ToD=0x0800 (NOP), PCInc_Out_ToD=0x0000, Halted=0, err=0; Valid_Out_ToD=0.
REQ-031 Reset during WAIT SHALL abandon the pending request; the instruction memory shares rst and drops its pending response.
REQ-032 First IMemReq SHALL assert in the first cycle after rst deasserts, with IMemAddr=0x0000.

Verification
REQ-033 Reset release, 1-cycle memory, mem[0x0000]=0x1234: cycle 1 IMemReq=1 addr 0x0000; cycle 2 IMemDone; cycle 3 Valid=1, Instr=0x1234, PCInc=0x0002; cycle 4 IMemReq addr 0x0002.
REQ-034 Stall_In=1 for 3 cycles in PRESENT -> Instr/PCInc/Valid held, IMemReq=0 throughout; fetch of next address one cycle after Stall_In=0.
REQ-035 PCsel=1, BJAddr=0x0040 with Stall_In=1 for 2 cycles then 0 -> single redirect, next IMemAddr=0x0040, err=0.
REQ-036 Halt_In_FromD=1 and PCsel=1 at consume -> Halted=1, IMemReq=0, Valid=0 for 20 cycles; then rst -> IMemAddr=0x0000, Halted=0.
REQ-037 PC=0xFFFE fetch -> PCInc_Out_ToD=0x0000, next IMemAddr=0x0000, err=0.
REQ-038 Redirect to BJAddr=0x0041 -> err=1, next IMemAddr=0x0040; separately, IMemDone=1 during FETCH -> err=1, held until rst.
